// File: rtl/hex_trail_renderer.sv
// Seven-segment frame renderer: head glyph, fading trail, reversal dp flash, idle blink; hex_o lags state by one register stage.
// Accepts a step every clock with no backpressure; out-of-range columns set a sticky err_o and are otherwise ignored.
module hex_trail_renderer #(
  parameter int NUM_DIGITS = 6,
  parameter int TRAIL_LEN  = 3,
  parameter int TURN_CYC   = 12_500_000,
  parameter int IDLE_CYC   = 50_000_000,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    step_i,
  input  logic [2:0]              col_i,
  input  logic                    direction_i,
  output logic [8*NUM_DIGITS-1:0] hex_o,
  output logic                    err_o
);

  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYC);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [2:0]              head_q;
  logic                    dir_q;
  logic [2:0]              hist_q [TRAIL_LEN];
  logic [TRAIL_LEN-1:0]    hist_vld_q;
  logic [TW-1:0]           turn_q;
  logic [IW-1:0]           idle_q;
  logic [BW-1:0]           blink_cnt_q;
  logic                    phase_q;
  logic                    err_q;
  logic [8*NUM_DIGITS-1:0] hex_q;
  logic [8*NUM_DIGITS-1:0] frame;
  logic [7:0]              glyph;

  logic col_ok;
  logic step_ok;
  logic moved;

  // Full-width compare so columns 6 and 7 are never aliased onto valid digits.
  assign col_ok  = ({29'd0, col_i} < 32'(NUM_DIGITS));
  assign step_ok = step_i & col_ok;
  assign moved   = step_ok & (col_i != head_q);

  function automatic logic [7:0] age_glyph(input int age_idx);
    case (age_idx)
      0:       age_glyph = 8'hBF;
      1:       age_glyph = 8'hF7;
      default: age_glyph = 8'hFE;
    endcase
  endfunction

  always_comb begin
    frame = '1;
    glyph = 8'hFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      glyph = 8'hFF;
      // Walk oldest to youngest so the youngest matching entry overrides.
      for (int i = TRAIL_LEN - 1; i >= 0; i--) begin
        if (hist_vld_q[i] && ({29'd0, hist_q[i]} == 32'(k))) begin
          glyph = age_glyph(i);
        end
      end
      if ({29'd0, head_q} == 32'(k)) begin
        glyph = phase_q ? 8'hC0 : 8'hFF;
        if (turn_q != '0) begin
          glyph[7] = 1'b0;
        end
      end
      frame[8*k +: 8] = glyph;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q      <= '0;
      dir_q       <= 1'b0;
      hist_vld_q  <= '0;
      for (int i = 0; i < TRAIL_LEN; i++) begin
        hist_q[i] <= '0;
      end
      turn_q      <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      err_q       <= 1'b0;
      hex_q       <= '1;
    end else begin
      // A repeated column is the controller's turnaround hold: no trail shift.
      if (moved) begin
        hist_q[0]     <= head_q;
        hist_vld_q[0] <= 1'b1;
        for (int i = 1; i < TRAIL_LEN; i++) begin
          hist_q[i]     <= hist_q[i-1];
          hist_vld_q[i] <= hist_vld_q[i-1];
        end
        head_q <= col_i;
      end

      if (step_ok && (direction_i != dir_q)) begin
        turn_q <= TURN_LOAD;
      end else if (turn_q != '0) begin
        turn_q <= turn_q - TW'(1);
      end

      if (step_ok) begin
        dir_q <= direction_i;
      end

      if (step_i && !col_ok) begin
        err_q <= 1'b1;
      end

      // Blink divider only runs once the idle counter has saturated.
      if (step_ok) begin
        idle_q      <= '0;
        blink_cnt_q <= '0;
        phase_q     <= 1'b1;
      end else if (idle_q != IDLE_MAX) begin
        idle_q <= idle_q + IW'(1);
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end

      hex_q <= frame;
    end
  end

  assign hex_o = hex_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_hex_trail_renderer.sv
// Scoreboard bench for hex_trail_renderer with short turn/idle/blink periods.
module tb_hex_trail_renderer;

  localparam int ND    = 6;
  localparam int TR    = 3;
  localparam int TURN  = 5;
  localparam int IDLE  = 8;
  localparam int BLINK = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          step_i = 1'b0;
  logic [2:0]    col_i = 3'd0;
  logic          direction_i = 1'b0;
  logic [8*ND-1:0] hex_o;
  logic          err_o;

  always #5 clk = ~clk;

  hex_trail_renderer #(
    .NUM_DIGITS(ND),
    .TRAIL_LEN (TR),
    .TURN_CYC  (TURN),
    .IDLE_CYC  (IDLE),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .step_i     (step_i),
    .col_i      (col_i),
    .direction_i(direction_i),
    .hex_o      (hex_o),
    .err_o      (err_o)
  );

  typedef struct packed {
    logic [8*ND-1:0] hex;
    logic            err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: trail as a youngest-first queue, blink derived from steps elapsed.
  int m_head  = 0;
  int m_dir   = 0;
  int m_hist[$];
  int m_turn  = 0;
  int m_since = 0;
  int m_err   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_phase();
    if (m_since < IDLE) return 1'b1;
    return (((m_since - IDLE) / BLINK) % 2) == 0;
  endfunction

  function automatic logic [8*ND-1:0] model_frame();
    logic [8*ND-1:0] f;
    logic [7:0] g;
    f = '1;
    for (int k = 0; k < ND; k++) begin
      g = 8'hFF;
      if (k == m_head) begin
        g = model_phase() ? 8'hC0 : 8'hFF;
        if (m_turn > 0) g[7] = 1'b0;
      end else begin
        for (int a = 0; a < m_hist.size(); a++) begin
          if (m_hist[a] == k) begin
            g = (a == 0) ? 8'hBF : (a == 1) ? 8'hF7 : 8'hFE;
            break;
          end
        end
      end
      f[8*k +: 8] = g;
    end
    return f;
  endfunction

  function automatic void model_update(input logic rst, input logic stp,
                                       input logic [2:0] col, input logic dir);
    bit valid;
    if (rst) begin
      m_head = 0; m_dir = 0; m_hist.delete();
      m_turn = 0; m_since = 0; m_err = 0;
      return;
    end
    valid = stp && (int'(col) < ND);
    if (stp && !valid) m_err = 1;
    if (valid && int'(dir) != m_dir) m_turn = TURN;
    else if (m_turn > 0) m_turn--;
    if (valid) begin
      if (int'(col) != m_head) begin
        m_hist.push_front(m_head);
        if (m_hist.size() > TR) void'(m_hist.pop_back());
        m_head = int'(col);
      end
      m_dir   = int'(dir);
      m_since = 0;
    end else begin
      m_since++;
    end
  endfunction

  // Drive one cycle, push the expectation for this edge, compare at the following negedge.
  task automatic tick(input logic rst, input logic stp, input logic [2:0] col, input logic dir);
    exp_t e;
    reset_i = rst; step_i = stp; col_i = col; direction_i = dir;
    e.hex = rst ? '1 : model_frame();
    model_update(rst, stp, col, dir);
    e.err = (m_err != 0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check_val("sb_hex", 64'(hex_o), 64'(e.hex));
    check_val("sb_err", 64'(err_o), 64'(e.err));
  endtask

  task automatic step(input logic [2:0] col, input logic dir);
    tick(1'b0, 1'b1, col, dir);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  function automatic logic [7:0] dig(input int k);
    return hex_o[8*k +: 8];
  endfunction

  initial begin
    // Reset for two cycles, then release.
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    check_val("rst_ff", 64'(hex_o), 64'(48'hFFFF_FFFF_FFFF));
    idle();
    check_val("rst_head", 64'(hex_o), 64'(48'hFFFF_FFFF_FFC0));
    check_val("rst_err", 64'(err_o), 64'd0);

    // Back-to-back steps building a full trail.
    step(3'd1, 1'b0);
    step(3'd2, 1'b0);
    step(3'd3, 1'b0);
    idle();
    check_val("trail", 64'(hex_o), 64'(48'hFFFF_C0BF_F7FE));

    // Sweep to the last digit, then a hold step that reverses direction.
    step(3'd4, 1'b0);
    step(3'd5, 1'b0);
    step(3'd5, 1'b1);
    for (int j = 1; j <= TURN; j++) begin
      idle();
      check_val("turn_dp", 64'(dig(5)), 64'(8'h40));
    end
    check_val("turn_noshift", 64'(hex_o), 64'(48'h40BF_F7FE_FFFF));
    idle();
    check_val("turn_end", 64'(dig(5)), 64'(8'hC0));
    step(3'd4, 1'b1);
    idle();
    check_val("turn_next", 64'(hex_o), 64'(48'hBFC0_FEFF_FFFF));

    // Idle blink after a step to column 2.
    step(3'd2, 1'b1);
    for (int j = 1; j <= 26; j++) begin
      idle();
      if (j <= IDLE + BLINK)
        check_val("blink_on", 64'(dig(2)), 64'(8'hC0));
      else if ((((j - IDLE - BLINK - 1) / BLINK) % 2) == 0)
        check_val("blink_off", 64'(dig(2)), 64'(8'hFF));
      else
        check_val("blink_on2", 64'(dig(2)), 64'(8'hC0));
    end
    step(3'd3, 1'b1);
    for (int j = 0; j < 6; j++) begin
      idle();
      check_val("blink_stop", 64'(dig(3)), 64'(8'hC0));
    end

    // Out-of-range columns: sticky error, frame unaffected.
    step(3'd6, 1'b0);
    check_val("err_set", 64'(err_o), 64'd1);
    idle();
    check_val("err_nochg", 64'(dig(3)), 64'(8'hC0));
    step(3'd7, 1'b1);
    step(3'd4, 1'b1);
    step(3'd5, 1'b1);
    idle();
    check_val("err_sticky", 64'(err_o), 64'd1);
    check_val("err_frame", 64'(dig(5)), 64'(8'hC0));

    // Reset while a turn flash is running with a trail present.
    step(3'd4, 1'b0);
    idle();
    check_val("flash_on", 64'(dig(4)), 64'(8'h40));
    tick(1'b1, 1'b0, 3'd0, 1'b0);
    check_val("rst2_ff", 64'(hex_o), 64'(48'hFFFF_FFFF_FFFF));
    idle();
    check_val("rst2_frame", 64'(hex_o), 64'(48'hFFFF_FFFF_FFC0));
    check_val("rst2_err", 64'(err_o), 64'd0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
